// File: rtl/therm_sort_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | therm_pkg                                                                 |
// | Thermometer-code helpers: monotonicity check and AND/OR compare-exchange. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package therm_pkg;

    // Widest supported code. Narrower codes are zero-extended, which keeps
    // both monotonicity and AND/OR results unchanged.
    localparam int THERM_MAX_W = 64;

    typedef logic [THERM_MAX_W-1:0] therm_max_t;

    function automatic logic therm_is_valid(input therm_max_t code);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < THERM_MAX_W; i++) begin
            if (code[i] && !code[i-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic therm_max_t therm_cmp_lo(input therm_max_t a, input therm_max_t b);
        return a & b;
    endfunction

    function automatic therm_max_t therm_cmp_hi(input therm_max_t a, input therm_max_t b);
        return a | b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/therm_sort_pipe_cx_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | therm_cx_stage                                                            |
// | One registered odd/even compare-exchange layer with valid/err carry.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module therm_cx_stage
    import therm_pkg::*;
#(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int ODD        = 0,
    parameter int DESCENDING = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    input  logic [M*N-1:0] in_data,
    input  logic           in_err,
    output logic           out_valid,
    output logic [M*N-1:0] out_data,
    output logic           out_err
);

    logic [M*N-1:0] w_next;

    function automatic logic [N-1:0] f_lo(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(therm_cmp_lo(therm_max_t'(a), therm_max_t'(b)));
    endfunction

    function automatic logic [N-1:0] f_hi(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(therm_cmp_hi(therm_max_t'(a), therm_max_t'(b)));
    endfunction

    // Each channel is either the lower member of a pair, the upper member,
    // or unpaired (edge channel on this layer's parity).
    for (genvar c = 0; c < M; c++) begin : g_ch
        localparam bit c_is_lo = ((c % 2) == ODD) && (c + 1 < M);
        localparam bit c_is_hi = (c >= 1) && (((c + 1) % 2) == ODD);

        if (c_is_lo) begin : g_lo
            if (DESCENDING != 0) begin : g_desc
                assign w_next[c*N +: N] = f_hi(in_data[c*N +: N], in_data[(c+1)*N +: N]);
            end else begin : g_asc
                assign w_next[c*N +: N] = f_lo(in_data[c*N +: N], in_data[(c+1)*N +: N]);
            end
        end else if (c_is_hi) begin : g_hi
            if (DESCENDING != 0) begin : g_desc
                assign w_next[c*N +: N] = f_lo(in_data[(c-1)*N +: N], in_data[c*N +: N]);
            end else begin : g_asc
                assign w_next[c*N +: N] = f_hi(in_data[(c-1)*N +: N], in_data[c*N +: N]);
            end
        end else begin : g_pass
            assign w_next[c*N +: N] = in_data[c*N +: N];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= w_next;
            out_err   <= in_err;
        end
    end

endmodule
`default_nettype wire

// File: rtl/therm_sort_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | therm_sort_pipe                                                           |
// | M-stage odd-even transposition sorter for thermometer codes, with        |
// | valid/ready streaming and malformed-code flagging.                        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module therm_sort_pipe
    import therm_pkg::*;
#(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int DESCENDING = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M*N-1:0] out_data,
    output logic           out_err
);

    typedef logic [N-1:0] therm_t;

    logic           w_adv;
    logic           w_in_err;
    logic [M-1:0]   w_ch_ok;
    therm_t         w_ch_code [M];
    logic [M:0]     w_valid;
    logic [M:0]     w_err;
    logic [M*N-1:0] w_data [M+1];

    // Whole pipe moves in lockstep; bubbles are carried, not squeezed out.
    assign w_adv    = out_ready || !out_valid;
    assign in_ready = w_adv;

    for (genvar c = 0; c < M; c++) begin : g_chk
        assign w_ch_code[c] = in_data[c*N +: N];
        assign w_ch_ok[c]   = therm_is_valid(therm_max_t'(w_ch_code[c]));
    end

    assign w_in_err = ~&w_ch_ok;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_err[0]   = w_in_err;

    for (genvar s = 0; s < M; s++) begin : g_stage
        therm_cx_stage #(
            .N          (N),
            .M          (M),
            .ODD        (s % 2),
            .DESCENDING (DESCENDING)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (w_adv),
            .in_valid  (w_valid[s]),
            .in_data   (w_data[s]),
            .in_err    (w_err[s]),
            .out_valid (w_valid[s+1]),
            .out_data  (w_data[s+1]),
            .out_err   (w_err[s+1])
        );
    end

    assign out_valid = w_valid[M];
    assign out_data  = w_data[M];
    assign out_err   = w_err[M];

endmodule
`default_nettype wire

// File: tb/tb_therm_sort_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_therm_sort_pipe                                                        |
// | Directed bench: ascending M=4 sorter and descending M=5 sorter.           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_therm_sort_pipe;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;

    logic        d_in_valid;
    logic        d_in_ready;
    logic [19:0] d_in_data;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [19:0] d_out_data;
    logic        d_out_err;

    int n_assert;
    int n_fail;

    therm_sort_pipe #(.N(4), .M(4), .DESCENDING(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    therm_sort_pipe #(.N(4), .M(5), .DESCENDING(1)) u_desc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_data),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_data),
        .out_err   (d_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic seen;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        d_in_valid  = 1'b0;
        d_in_data   = '0;
        d_out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_d_out_valid", {31'd0, d_out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Basic: ch0..3 = 1111,0001,0111,0000
        in_valid = 1'b1;
        in_data  = 16'h071F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("basic_early_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_data", {16'd0, out_data}, 32'h0000F710);
        chk("basic_err", {31'd0, out_err}, 32'd0);
        tick();
        chk("basic_drained", {31'd0, out_valid}, 32'd0);

        // Streaming: 4 back-to-back vectors
        in_valid = 1'b1;
        in_data = 16'h1F03; tick();
        in_data = 16'h3177; tick();
        in_data = 16'hFFFF; tick();
        in_data = 16'h0301; tick();
        in_valid = 1'b0;
        chk("strm0_valid", {31'd0, out_valid}, 32'd1);
        chk("strm0_data", {16'd0, out_data}, 32'h0000F310);
        tick();
        chk("strm1_valid", {31'd0, out_valid}, 32'd1);
        chk("strm1_data", {16'd0, out_data}, 32'h00007731);
        tick();
        chk("strm2_valid", {31'd0, out_valid}, 32'd1);
        chk("strm2_data", {16'd0, out_data}, 32'h0000FFFF);
        tick();
        chk("strm3_valid", {31'd0, out_valid}, 32'd1);
        chk("strm3_data", {16'd0, out_data}, 32'h00003100);
        tick();
        chk("strm_end", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill, stall 3 cycles, release
        in_valid = 1'b1;
        in_data = 16'h1F03; tick();
        in_data = 16'h3177; tick();
        in_data = 16'hFFFF; tick();
        in_data = 16'h0301; tick();
        in_data   = 16'h071F;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {16'd0, out_data}, 32'h0000F310);
            chk("bp_hold_err", {31'd0, out_err}, 32'd0);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_d1", {16'd0, out_data}, 32'h00007731);
        tick();
        chk("bp_d2", {16'd0, out_data}, 32'h0000FFFF);
        tick();
        chk("bp_d3", {16'd0, out_data}, 32'h00003100);
        tick();
        chk("bp_d4_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_d4", {16'd0, out_data}, 32'h0000F710);
        tick();
        chk("bp_end", {31'd0, out_valid}, 32'd0);

        // Malformed: middle vector has ch1 = 0101
        in_valid = 1'b1;
        in_data = 16'hFFFF; tick();
        in_data = 16'h1753; tick();
        in_data = 16'h0301; tick();
        in_valid = 1'b0;
        tick();
        chk("mal_prev_data", {16'd0, out_data}, 32'h0000FFFF);
        chk("mal_prev_err", {31'd0, out_err}, 32'd0);
        tick();
        chk("mal_valid", {31'd0, out_valid}, 32'd1);
        chk("mal_data", {16'd0, out_data}, 32'h00007711);
        chk("mal_err", {31'd0, out_err}, 32'd1);
        tick();
        chk("mal_next_data", {16'd0, out_data}, 32'h00003100);
        chk("mal_next_err", {31'd0, out_err}, 32'd0);
        tick();

        // Reset mid-flight
        in_valid = 1'b1;
        in_data = 16'h1F03; tick();
        in_data = 16'h3177; tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rmf_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmf_valid", {31'd0, out_valid}, 32'd0);
        chk("rmf_data", {16'd0, out_data}, 32'd0);
        chk("rmf_err", {31'd0, out_err}, 32'd0);
        #2;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rmf_no_ghost", {31'd0, seen}, 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0301;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rmf_lat_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rmf_lat_valid", {31'd0, out_valid}, 32'd1);
        chk("rmf_lat_data", {16'd0, out_data}, 32'h00003100);

        // Descending, M=5
        d_in_valid = 1'b1;
        d_in_data = 20'h710F3; tick();
        d_in_data = 20'h33333; tick();
        d_in_valid = 1'b0;
        tick();
        tick();
        chk("desc_early", {31'd0, d_out_valid}, 32'd0);
        tick();
        chk("desc_valid", {31'd0, d_out_valid}, 32'd1);
        chk("desc_data", {12'd0, d_out_data}, 32'h0000137F);
        chk("desc_err", {31'd0, d_out_err}, 32'd0);
        tick();
        chk("desc_tie_valid", {31'd0, d_out_valid}, 32'd1);
        chk("desc_tie_data", {12'd0, d_out_data}, 32'h00033333);
        tick();
        chk("desc_end", {31'd0, d_out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
